// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// req/ack memory, with a sticky FAULT state on memory timeout.
module multicycle_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [3:0] func,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [2:0] alu_func,
    output logic       imm_enable,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       retire,
    output logic       illegal,
    output logic       fault,
    output logic [2:0] state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    localparam logic [2:0] C_R   = 3'd0;
    localparam logic [2:0] C_I   = 3'd1;
    localparam logic [2:0] C_LW  = 3'd2;
    localparam logic [2:0] C_SW  = 3'd3;
    localparam logic [2:0] C_J   = 3'd4;
    localparam logic [2:0] C_ILL = 3'd5;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       cls_reg, alu_reg;
    logic [2:0]       dec_cls, dec_alu;
    logic             timeout_hit;

    // Instruction classification; lw/sw address math is always an add.
    always_comb begin
        dec_cls = C_ILL;
        dec_alu = ALU_NONE;
        case (op)
            6'b000000: begin
                dec_cls = C_R;
                case (func)
                    4'b0000: dec_alu = ALU_ADD;
                    4'b0010: dec_alu = ALU_SUB;
                    4'b0100: dec_alu = ALU_AND;
                    4'b0101: dec_alu = ALU_OR;
                    4'b1010: dec_alu = ALU_SLT;
                    default: dec_cls = C_ILL;
                endcase
            end
            6'b001000: begin dec_cls = C_I;  dec_alu = ALU_ADD; end
            6'b001100: begin dec_cls = C_I;  dec_alu = ALU_AND; end
            6'b001101: begin dec_cls = C_I;  dec_alu = ALU_OR;  end
            6'b001010: begin dec_cls = C_I;  dec_alu = ALU_SLT; end
            6'b100011: begin dec_cls = C_LW; dec_alu = ALU_ADD; end
            6'b101011: begin dec_cls = C_SW; dec_alu = ALU_ADD; end
            6'b000010: dec_cls = C_J;
            default:   dec_cls = C_ILL;
        endcase
        if (dec_cls == C_ILL) begin
            dec_alu = ALU_NONE;
        end
    end

    // An ack in the limit cycle still completes the access.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == TIMEOUT_CNT) && !mem_ack;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: begin
                if (mem_ack) begin
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                if (dec_cls == C_J || dec_cls == C_ILL) begin
                    state_next = S_FETCH;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls_reg == C_LW || cls_reg == C_SW) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_next = (cls_reg == C_LW) ? S_WB : S_FETCH;
                end else if (timeout_hit) begin
                    state_next = S_FAULT;
                end
            end
            S_WB:    state_next = S_FETCH;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_FETCH;
        endcase
    end

    // Counter only runs while a request waits in place; any move or ack clears it.
    always_comb begin
        cnt_next = '0;
        if ((state_reg == S_FETCH || state_reg == S_MEM) &&
            state_next == state_reg && !mem_ack) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
            cnt_reg   <= '0;
            cls_reg   <= C_R;
            alu_reg   <= ALU_NONE;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == S_DECODE) begin
                cls_reg <= dec_cls;
                alu_reg <= dec_alu;
            end
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_func   = ALU_NONE;
        imm_enable = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        fault      = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ack;
                pc_write = mem_ack;
            end
            S_DECODE: begin
                if (dec_cls == C_J) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                    retire   = 1'b1;
                end else if (dec_cls == C_ILL) begin
                    illegal = 1'b1;
                    retire  = 1'b1;
                end
            end
            S_EXEC: begin
                alu_func   = alu_reg;
                imm_enable = (cls_reg != C_R);
            end
            S_MEM: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                alu_func   = ALU_ADD;
                imm_enable = 1'b1;
                mem_we     = (cls_reg == C_SW);
                retire     = mem_ack && (cls_reg == C_SW);
                mem_to_reg = mem_ack && (cls_reg == C_LW);
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (cls_reg == C_R);
                mem_to_reg = (cls_reg == C_LW);
                retire     = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    assign state = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: random instruction stream against a per-instruction
// expected-cycle list, plus directed timeout and reset-in-MEM cases.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [3:0] func;
    logic       mem_ack;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src;
    logic [2:0] alu_func;
    logic       imm_enable, reg_write, reg_dst, mem_to_reg, retire, illegal, fault;
    logic [2:0] state;

    multicycle_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_func(alu_func),
        .imm_enable(imm_enable), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .retire(retire), .illegal(illegal),
        .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [12:0] F_FAULT  = 13'h0001;
    localparam logic [12:0] F_MREQ   = 13'h0002;
    localparam logic [12:0] F_MWE    = 13'h0004;
    localparam logic [12:0] F_IORD   = 13'h0008;
    localparam logic [12:0] F_IRW    = 13'h0010;
    localparam logic [12:0] F_PCW    = 13'h0020;
    localparam logic [12:0] F_PCSRC  = 13'h0040;
    localparam logic [12:0] F_IMM    = 13'h0080;
    localparam logic [12:0] F_REGW   = 13'h0100;
    localparam logic [12:0] F_REGDST = 13'h0200;
    localparam logic [12:0] F_M2R    = 13'h0400;
    localparam logic [12:0] F_RET    = 13'h0800;
    localparam logic [12:0] F_ILL    = 13'h1000;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_J = 4, K_ILL = 5;

    logic [18:0] obs;
    assign obs = {state, alu_func, illegal, retire, mem_to_reg, reg_dst, reg_write,
                  imm_enable, pc_src, pc_write, ir_write, iord, mem_we, mem_req, fault};

    typedef struct packed {
        logic [5:0]  op;
        logic [3:0]  func;
        logic        ack;
        logic [18:0] exp;
    } cyc_t;

    cyc_t q[$];
    int tests = 0;
    int failed = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [18:0] ev(input logic [2:0] st, input logic [2:0] alu,
                                       input logic [12:0] fl);
        return {st, alu, fl};
    endfunction

    // Lookup of the instruction set: class and ALU code.
    task automatic classify(input logic [5:0] o, input logic [3:0] f,
                            output int cls, output logic [2:0] alu);
        cls = K_ILL;
        alu = 3'b000;
        case (o)
            6'h00: begin
                cls = K_R;
                case (f)
                    4'h0: alu = 3'b001;
                    4'h2: alu = 3'b010;
                    4'h4: alu = 3'b011;
                    4'h5: alu = 3'b100;
                    4'hA: alu = 3'b101;
                    default: cls = K_ILL;
                endcase
            end
            6'h08: begin cls = K_I; alu = 3'b001; end
            6'h0C: begin cls = K_I; alu = 3'b011; end
            6'h0D: begin cls = K_I; alu = 3'b100; end
            6'h0A: begin cls = K_I; alu = 3'b101; end
            6'h23: begin cls = K_LW; alu = 3'b001; end
            6'h2B: begin cls = K_SW; alu = 3'b001; end
            6'h02: cls = K_J;
            default: cls = K_ILL;
        endcase
    endtask

    task automatic push(input logic [5:0] o, input logic [3:0] f, input logic a,
                        input logic [18:0] e);
        cyc_t c;
        c.op = o;
        c.func = f;
        c.ack = a;
        c.exp = e;
        q.push_back(c);
    endtask

    // Expected cycle list for one instruction; op/func and stray acks are random
    // outside the cycles where they matter.
    task automatic build(input logic [5:0] o, input logic [3:0] f, input int wf, input int wm);
        int cls;
        logic [2:0] alu;
        logic [12:0] base;
        classify(o, f, cls, alu);
        $display("[TB] instr op=%b func=%b class=%0d fetch_wait=%0d mem_wait=%0d",
                 o, f, cls, wf, wm);
        for (int i = 0; i < wf; i++)
            push(6'($urandom), 4'($urandom), 1'b0, ev(3'd0, 3'd0, F_MREQ));
        push(6'($urandom), 4'($urandom), 1'b1, ev(3'd0, 3'd0, F_MREQ | F_IRW | F_PCW));
        if (cls == K_J) begin
            push(o, f, 1'($urandom), ev(3'd1, 3'd0, F_PCW | F_PCSRC | F_RET));
            return;
        end
        if (cls == K_ILL) begin
            push(o, f, 1'($urandom), ev(3'd1, 3'd0, F_ILL | F_RET));
            return;
        end
        push(o, f, 1'($urandom), ev(3'd1, 3'd0, 13'h0));
        push(6'($urandom), 4'($urandom), 1'($urandom),
             ev(3'd2, alu, (cls == K_R) ? 13'h0 : F_IMM));
        if (cls == K_LW || cls == K_SW) begin
            base = F_MREQ | F_IORD | F_IMM | ((cls == K_SW) ? F_MWE : 13'h0);
            for (int i = 0; i < wm; i++)
                push(6'($urandom), 4'($urandom), 1'b0, ev(3'd3, 3'b001, base));
            push(6'($urandom), 4'($urandom), 1'b1,
                 ev(3'd3, 3'b001, base | ((cls == K_SW) ? F_RET : F_M2R)));
            if (cls == K_SW) return;
        end
        push(6'($urandom), 4'($urandom), 1'($urandom),
             ev(3'd4, 3'd0, F_REGW | F_RET | ((cls == K_R) ? F_REGDST : 13'h0) |
                            ((cls == K_LW) ? F_M2R : 13'h0)));
    endtask

    task automatic gen_random();
        int r_funcs[5] = '{0, 2, 4, 5, 10};
        int i_ops[4]   = '{8, 12, 13, 10};
        logic [5:0] o;
        logic [3:0] f;
        int k;
        k = $urandom_range(0, 9);
        f = 4'($urandom);
        if (k <= 3) begin
            o = 6'h00;
            if ($urandom_range(0, 3) != 0) f = 4'(r_funcs[$urandom_range(0, 4)]);
        end else if (k <= 5) o = 6'(i_ops[$urandom_range(0, 3)]);
        else if (k == 6) o = 6'h23;
        else if (k == 7) o = 6'h2B;
        else if (k == 8) o = 6'h02;
        else o = 6'($urandom);
        build(o, f, $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    task automatic run_cycles(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = q.pop_front();
            op = c.op;
            func = c.func;
            mem_ack = c.ack;
            #1;
            check_val($sformatf("st%0d", c.exp[18:16]), 32'(obs), 32'(c.exp));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_all();
        run_cycles(q.size());
    endtask

    initial begin
        rst = 1'b1;
        op = '0;
        func = '0;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        check_val("reset", 32'(obs), 32'(ev(3'd0, 3'd0, F_MREQ)));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed instructions from the plan.
        build(6'h00, 4'h0, 0, 0); run_all();
        build(6'h23, 4'h0, 0, 3); run_all();
        build(6'h2B, 4'h0, 0, 0); run_all();
        build(6'h02, 4'h0, 0, 0); run_all();
        build(6'h3F, 4'h0, 0, 0); run_all();
        build(6'h00, 4'hF, 0, 0); run_all();

        for (int n = 0; n < 60; n++) begin
            gen_random();
            run_all();
        end

        // Ack on the limit cycle wins in both FETCH and MEM.
        build(6'h02, 4'h0, 15, 0); run_all();
        build(6'h23, 4'h0, 0, 15); run_all();

        // Sixteen unacknowledged FETCH cycles, then sticky FAULT.
        $display("[TB] instr fetch timeout");
        for (int i = 0; i < 16; i++) begin
            op = 6'($urandom);
            mem_ack = 1'b0;
            #1;
            check_val("flt_wait", 32'(obs), 32'(ev(3'd0, 3'd0, F_MREQ)));
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'($urandom);
            op = 6'($urandom);
            #1;
            check_val("fault", 32'(obs), 32'(ev(3'd5, 3'd0, F_FAULT)));
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        build(6'h08, 4'h0, 0, 0); run_all();

        // Reset during an sw MEM wait; the following ack belongs to FETCH.
        build(6'h2B, 4'h0, 0, 4);
        run_cycles(4);
        q.delete();
        rst = 1'b1;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        build(6'h02, 4'h0, 0, 0); run_all();
        build(6'h00, 4'h2, 1, 0); run_all();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
